// File: rtl/scramble_multibit_if.sv
// Bundles the beat stream, its handshakes and the per-packet channel controls of the
// multi-bit BLE whitening block.
interface scramble_multibit_if #(
  parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
  parameter int DATA_WIDTH               = 1
);
  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number;
  logic                                channel_number_load;
  logic                                whitening_en;
  logic [DATA_WIDTH-1:0]               data_in;
  logic                                data_in_valid;
  logic                                data_in_valid_last;
  logic                                data_in_ready;
  logic [DATA_WIDTH-1:0]               data_out;
  logic                                data_out_valid;
  logic                                data_out_valid_last;
  logic                                data_out_ready;

  modport master (
    output channel_number, channel_number_load, whitening_en,
    output data_in, data_in_valid, data_in_valid_last, data_out_ready,
    input  data_in_ready, data_out, data_out_valid, data_out_valid_last
  );

  modport slave (
    input  channel_number, channel_number_load, whitening_en,
    input  data_in, data_in_valid, data_in_valid_last, data_out_ready,
    output data_in_ready, data_out, data_out_valid, data_out_valid_last
  );
endinterface

// File: rtl/scramble_multibit.sv
// BLE data whitening (x^7+x^4+1) on DATA_WIDTH bits per beat, with ready/valid
// backpressure, per-packet bypass and automatic re-seed at packet end.
module scramble_multibit #(
  parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
  parameter int DATA_WIDTH               = 1
) (
  input logic               clk,
  input logic               rst_n,
  scramble_multibit_if.slave bus
);

  typedef logic [6:0] lfsr_t;

  // Index i of lfsr_t is LFSR position wi; w0 is always seeded to 1.
  function automatic lfsr_t seed_from(input logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] ch);
    lfsr_t      s;
    logic [5:0] c6;
    c6   = 6'(ch);
    s[0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      s[i] = c6[6-i];
    end
    return s;
  endfunction

  function automatic lfsr_t lfsr_step(input lfsr_t w);
    return {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
  endfunction

  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_q;
  logic                                whitening_q;
  lfsr_t                               lfsr_q;
  lfsr_t                               lfsr_d;
  logic [DATA_WIDTH-1:0]               data_out_q;
  logic                                out_valid_q;
  logic                                out_last_q;

  logic                  in_ready;
  logic                  beat_accept;
  logic                  whiten_now;
  lfsr_t                 load_seed;
  lfsr_t                 latched_seed;
  lfsr_t                 start_state;
  lfsr_t                 adv_state;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] whitened;

  assign in_ready     = !out_valid_q || bus.data_out_ready;
  assign beat_accept  = bus.data_in_valid && in_ready;
  assign load_seed    = seed_from(bus.channel_number);
  assign latched_seed = seed_from(channel_q);
  // A load in the same cycle as a beat whitens that beat from the fresh seed.
  assign start_state  = bus.channel_number_load ? load_seed : lfsr_q;
  assign whiten_now   = bus.channel_number_load ? bus.whitening_en : whitening_q;

  always_comb begin
    lfsr_t walk;
    walk = start_state;
    mask = '0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      mask[k] = walk[6];
      walk    = lfsr_step(walk);
    end
    adv_state = walk;
  end

  assign whitened = bus.data_in ^ (whiten_now ? mask : '0);

  always_comb begin
    lfsr_d = lfsr_q;
    if (bus.channel_number_load) begin
      lfsr_d = (beat_accept && !bus.data_in_valid_last) ? adv_state : load_seed;
    end else if (beat_accept) begin
      lfsr_d = bus.data_in_valid_last ? latched_seed : adv_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      channel_q   <= '0;
      whitening_q <= 1'b1;
      lfsr_q      <= 7'b0000001;
    end else begin
      lfsr_q <= lfsr_d;
      if (bus.channel_number_load) begin
        channel_q   <= bus.channel_number;
        whitening_q <= bus.whitening_en;
      end
    end
  end

  // The output stage only moves when it is empty or being drained downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (in_ready) begin
      out_valid_q <= beat_accept;
      out_last_q  <= beat_accept && bus.data_in_valid_last;
      if (beat_accept) begin
        data_out_q <= whitened;
      end
    end
  end

  assign bus.data_in_ready       = in_ready;
  assign bus.data_out            = data_out_q;
  assign bus.data_out_valid      = out_valid_q;
  assign bus.data_out_valid_last = out_last_q;

endmodule

// File: tb/tb_scramble_multibit.sv
// Directed bench for scramble_multibit: a DATA_WIDTH=1 and a DATA_WIDTH=8 instance
// driven from one linear sequence, with hand-computed and modelled whitening values.
module tb_scramble_multibit;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] pkt_in  [32];
  logic [7:0] exp_out [32];
  logic [6:0] m_state;

  scramble_multibit_if #(.CHANNEL_NUMBER_BIT_WIDTH(6), .DATA_WIDTH(1)) b1 ();
  scramble_multibit_if #(.CHANNEL_NUMBER_BIT_WIDTH(6), .DATA_WIDTH(8)) b8 ();

  scramble_multibit #(.CHANNEL_NUMBER_BIT_WIDTH(6), .DATA_WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  scramble_multibit #(.CHANNEL_NUMBER_BIT_WIDTH(6), .DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference whitening: s[i] holds position wi, output tap is w6.
  function automatic logic [6:0] model_seed(input int ch);
    return {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
  endfunction

  task automatic model_whiten(input logic [7:0] d, inout logic [6:0] s, output logic [7:0] o);
    logic fb;
    o = '0;
    for (int k = 0; k < 8; k++) begin
      fb   = s[6];
      o[k] = d[k] ^ fb;
      s    = {s[5], s[4], s[3] ^ fb, s[2], s[1], s[0], fb};
    end
  endtask

  task automatic apply_load1(input logic [5:0] ch, input logic wen);
    @(negedge clk);
    b1.channel_number = ch; b1.whitening_en = wen; b1.channel_number_load = 1'b1;
    @(negedge clk);
    b1.channel_number_load = 1'b0;
  endtask

  task automatic apply_load8(input logic [5:0] ch, input logic wen);
    @(negedge clk);
    b8.channel_number = ch; b8.whitening_en = wen; b8.channel_number_load = 1'b1;
    @(negedge clk);
    b8.channel_number_load = 1'b0;
  endtask

  // One bit every 16 cycles; checks 1-cycle latency and that valid drops afterwards.
  task automatic apply_bit1(input logic d, input logic last, input logic exp_bit, input string tag);
    @(negedge clk);
    b1.data_in = d; b1.data_in_valid = 1'b1; b1.data_in_valid_last = last;
    @(posedge clk); #1;
    b1.data_in_valid = 1'b0; b1.data_in_valid_last = 1'b0;
    check_output({tag, "_valid"}, b1.data_out_valid, 1'b1);
    check_output({tag, "_data"}, b1.data_out, exp_bit);
    check_output({tag, "_last"}, b1.data_out_valid_last, last);
    @(posedge clk); #1;
    check_output({tag, "_drop"}, b1.data_out_valid, 1'b0);
    repeat (14) @(posedge clk);
  endtask

  task automatic apply_beat8(input logic [7:0] d, input logic last, input logic [7:0] exp_byte,
                             input string tag);
    @(negedge clk);
    b8.data_in = d; b8.data_in_valid = 1'b1; b8.data_in_valid_last = last;
    @(posedge clk); #1;
    b8.data_in_valid = 1'b0; b8.data_in_valid_last = 1'b0;
    check_output({tag, "_valid"}, b8.data_out_valid, 1'b1);
    check_output({tag, "_data"}, b8.data_out, exp_byte);
    check_output({tag, "_last"}, b8.data_out_valid_last, last);
  endtask

  // Streams pkt_in[0..n-1] as one packet, stalling the output for stall_len cycles.
  task automatic apply_stream8(input int n, input int stall_at, input int stall_len, input string tag);
    int         in_idx = 0;
    int         out_idx = 0;
    int         cyc = 0;
    logic [7:0] held = '0;
    while (out_idx < n && cyc < 500) begin
      @(negedge clk);
      b8.data_out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      b8.data_in_valid      = (in_idx < n);
      b8.data_in            = (in_idx < n) ? pkt_in[in_idx] : 8'h00;
      b8.data_in_valid_last = (in_idx == n - 1);
      #1;
      if (!b8.data_out_ready && b8.data_out_valid) begin
        check_output({tag, "_stall_ready"}, b8.data_in_ready, 1'b0);
        if (cyc > stall_at) check_output({tag, "_stall_hold"}, b8.data_out, held);
        held = b8.data_out;
      end
      if (b8.data_out_valid && b8.data_out_ready) begin
        check_output({tag, "_data"}, b8.data_out, exp_out[out_idx]);
        check_output({tag, "_last"}, b8.data_out_valid_last, (out_idx == n - 1));
        out_idx++;
      end
      if (b8.data_in_valid && b8.data_in_ready) in_idx++;
      @(posedge clk);
      cyc++;
    end
    #1;
    b8.data_in_valid = 1'b0; b8.data_in_valid_last = 1'b0; b8.data_out_ready = 1'b1;
    check_output({tag, "_count"}, out_idx, n);
    @(posedge clk); #1;
    check_output({tag, "_idle"}, b8.data_out_valid, 1'b0);
  endtask

  task automatic model_packet(input int ch, input int n);
    m_state = model_seed(ch);
    for (int i = 0; i < n; i++) model_whiten(pkt_in[i], m_state, exp_out[i]);
  endtask

  initial begin
    logic [9:0] exp_ch0;
    logic [4:0] exp_ch37;
    logic [7:0] second;
    logic [7:0] first;

    b1.channel_number = '0; b1.channel_number_load = 1'b0; b1.whitening_en = 1'b1;
    b1.data_in = '0; b1.data_in_valid = 1'b0; b1.data_in_valid_last = 1'b0; b1.data_out_ready = 1'b1;
    b8.channel_number = '0; b8.channel_number_load = 1'b0; b8.whitening_en = 1'b1;
    b8.data_in = '0; b8.data_in_valid = 1'b0; b8.data_in_valid_last = 1'b0; b8.data_out_ready = 1'b1;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_data8", b8.data_out, 8'h00);
    check_output("rst_valid8", b8.data_out_valid, 1'b0);
    check_output("rst_last8", b8.data_out_valid_last, 1'b0);
    check_output("rst_ready8", b8.data_in_ready, 1'b1);
    check_output("rst_valid1", b1.data_out_valid, 1'b0);
    check_output("rst_ready1", b1.data_in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Channel 0, ten zero bits (index 0 first).
    exp_ch0 = 10'b1001000000;
    apply_load1(6'd0, 1'b1);
    for (int i = 0; i < 10; i++) apply_bit1(1'b0, (i == 9), exp_ch0[i], $sformatf("ch0_bit%0d", i));

    // Channel 37: whitening byte 0x8D, bits in time order 1,0,1,1,0.
    exp_ch37 = 5'b01101;
    apply_load1(6'd37, 1'b1);
    for (int i = 0; i < 5; i++) apply_bit1(1'b0, (i == 4), exp_ch37[i], $sformatf("ch37_bit%0d", i));
    for (int i = 0; i < 5; i++) apply_bit1(1'b0, (i == 4), exp_ch37[i], $sformatf("ch37_reseed_bit%0d", i));

    apply_load8(6'd0, 1'b1);
    apply_beat8(8'h00, 1'b1, 8'h40, "w8_ch0");

    for (int i = 0; i < 32; i++) pkt_in[i] = 8'($urandom);
    apply_load8(6'd21, 1'b1);
    model_packet(21, 32);
    apply_stream8(32, 1000, 0, "rand32");

    for (int i = 0; i < 8; i++) pkt_in[i] = 8'($urandom);
    apply_load8(6'd9, 1'b1);
    model_packet(9, 8);
    apply_stream8(8, 3, 5, "stall");

    apply_load8(6'd12, 1'b0);
    apply_beat8(8'hA5, 1'b0, 8'hA5, "bypass0");
    apply_beat8(8'h3C, 1'b1, 8'h3C, "bypass1");
    apply_load8(6'd0, 1'b1);
    apply_beat8(8'h00, 1'b1, 8'h40, "after_bypass");

    // Load coincident with first beat; second beat continues from seed + 8 steps.
    m_state = model_seed(37);
    model_whiten(8'h00, m_state, first);
    model_whiten(8'h00, m_state, second);
    @(negedge clk);
    b8.channel_number = 6'd37; b8.whitening_en = 1'b1; b8.channel_number_load = 1'b1;
    b8.data_in = 8'h00; b8.data_in_valid = 1'b1; b8.data_in_valid_last = 1'b0;
    @(posedge clk); #1;
    b8.channel_number_load = 1'b0; b8.data_in_valid = 1'b0;
    check_output("coinc_nibble", b8.data_out[3:0], 4'b1101);
    check_output("coinc_byte", b8.data_out, 8'h8D);
    check_output("coinc_model", b8.data_out, first);
    apply_beat8(8'h00, 1'b1, second, "coinc_second");

    apply_load8(6'd5, 1'b1);
    m_state = model_seed(5);
    model_whiten(8'h00, m_state, first);
    apply_beat8(8'h00, 1'b0, first, "pre_reset");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("async_rst_valid", b8.data_out_valid, 1'b0);
    check_output("async_rst_data", b8.data_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    apply_beat8(8'h00, 1'b1, 8'h40, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
